pc_branch_unit: RTL and testbench
=================================

Name: pc_branch_unit

Overview:
Fetch-stage program-counter generator, parametrised in address width, immediate width and shift. Computes branch targets (PC + PC_INC + sign-extended, shifted immediate) and carries a small direct-mapped branch target buffer (BTB) for next-PC prediction. Applies single-cycle redirects on branch resolution from execute. Sits between fetch (instruction memory) and execute.

Parameters:
ADDR_W, 32, PC and target width
IMM_W, 24, branch immediate width
IMM_SHIFT, 2, left shift applied to the immediate after sign extension
PC_INC, 4, sequential PC increment
RESET_PC, 0, PC value held during reset
BTB_DEPTH, 8, number of BTB entries; must be a power of two ≥ 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc  out  ADDR_W  current fetch address
pc_valid  out  1  pc is a valid fetch request
pc_ready  in  1  fetch accepts pc this cycle
pred_taken  out  1  BTB hit on current pc; travels down the pipe with the instruction
br_valid  in  1  execute resolves a branch this cycle
br_taken  in  1  resolved direction
br_pred_taken  in  1  pred_taken originally issued with this branch
br_pc  in  ADDR_W  address of the resolved branch
br_imm  in  IMM_W  signed word offset of the branch

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, pc_valid=0, redirect=0, all BTB valid bits cleared. pc_valid goes to 1 at the first clock edge after rst_n rises.
- Target arithmetic: target = br_pc + PC_INC + (sext_ADDR_W(br_imm) << IMM_SHIFT), taken modulo 2^ADDR_W. Sign bit is br_imm[IMM_W-1], sampled before shifting. fallthrough = br_pc + PC_INC. Both wrap silently.
- mispredict = br_valid & (br_taken != br_pred_taken).
- Next-PC priority, evaluated each edge:
  - 1. mispredict: pc <= br_taken ? target : fallthrough.
  - 2. pc_valid & !pc_ready: hold pc.
  - 3. pc_valid & pc_ready & BTB hit: pc <= stored target.
  - 4. pc_valid & pc_ready: pc <= pc + PC_INC.
- redirect: registered. It is 1 for exactly the one cycle after an edge that acted on a mispredict, otherwise 0. A redirect discards any held (unaccepted) pc.
- Redirect latency is 1 cycle: br_valid sampled at edge N, so corrected pc and redirect=1 are visible from edge N to edge N+1.
- BTB organisation: direct-mapped. index = pc[IMM_SHIFT +: log2(BTB_DEPTH)]. Each entry holds {valid, full ADDR_W tag, ADDR_W target}.
- BTB lookup: combinational on the current pc. pred_taken = valid & (tag == pc). pred_taken is 0 whenever pc_valid=0.
- BTB update on br_valid:
  - br_taken=1: write {1, br_pc, target} into entry index(br_pc).
  - br_taken=0 and the entry's tag == br_pc: clear its valid bit.
- Update takes effect at the edge. A same-cycle lookup of the same index sees the old contents.
- br_valid is honoured regardless of pc_valid/pc_ready. br_pred_taken is trusted as given.

Optional Feature:
PC_BRANCH_PERF_EN: when defined, adds two outputs, br_count and mispredict_count, each 16 bits.
- br_count increments on every br_valid.
- mispredict_count increments on every mispredict.
- Both saturate at 0xFFFF and reset to 0.
When PC_BRANCH_PERF_EN is undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then release, pc_ready=1, no branches -> pc_valid=0 during reset; pc sequence 0x0, 0x4, 0x8, 0xC; pred_taken=0; redirect=0.
- At pc=0x8, drive pc_ready=0 for 3 cycles -> pc holds 0x8 with pc_valid=1; it advances to 0xC on the cycle pc_ready returns to 1.
- br_valid, br_pc=0x100, br_imm=0xFFFFFE, br_taken=1, br_pred_taken=0 -> next cycle pc=0xFC, redirect=1 for one cycle; BTB entry index 0 now holds tag 0x100, target 0xFC.
- Fetch reaches pc=0x100 -> pred_taken=1, next pc=0xFC with no redirect. Then resolve with br_taken=1, br_pred_taken=1 -> redirect stays 0 and pc continues unaffected.
- Resolve br_pc=0x100, br_taken=0, br_pred_taken=1 -> pc=0x104, redirect=1; entry invalidated; the next fetch of 0x100 gives pred_taken=0.
- Wrap and priority: br_pc=0xFFFFFFF8, br_imm=0x000001, br_taken=1, br_pred_taken=0, issued while pc_ready=0 -> pc=0x00000000, redirect=1; the held pc is dropped. Also check br_imm=0x7FFFFF at br_pc=0 -> target 0x02000000.

Source files
------------

// File: rtl/pc_branch_unit.sv
// Fetch-stage PC generator with branch target arithmetic and a direct-mapped BTB.
// Define PC_BRANCH_PERF_EN to add saturating branch/mispredict counters.
module pc_branch_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                IMM_W     = 24,
    parameter int                IMM_SHIFT = 2,
    parameter int                PC_INC    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BTB_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    input  logic              pc_ready,
    output logic              pred_taken,
    output logic              redirect,
    input  logic              br_valid,
    input  logic              br_taken,
    input  logic              br_pred_taken,
    input  logic [ADDR_W-1:0] br_pc,
`ifdef PC_BRANCH_PERF_EN
    output logic [15:0]       br_count,
    output logic [15:0]       mispredict_count,
`endif
    input  logic [IMM_W-1:0]  br_imm
);

    localparam int                IDX_W    = $clog2(BTB_DEPTH);
    localparam logic [ADDR_W-1:0] PC_INC_W = ADDR_W'(PC_INC);

    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic                 pc_valid_q, pc_valid_d;
    logic                 redirect_q, redirect_d;
    logic [BTB_DEPTH-1:0] btb_valid_q, btb_valid_d;
    logic [ADDR_W-1:0]    btb_tag_q [BTB_DEPTH];
    logic [ADDR_W-1:0]    btb_tag_d [BTB_DEPTH];
    logic [ADDR_W-1:0]    btb_tgt_q [BTB_DEPTH];
    logic [ADDR_W-1:0]    btb_tgt_d [BTB_DEPTH];

    logic [IDX_W-1:0]     fetch_idx, br_idx;
    logic [ADDR_W-1:0]    imm_sext, fallthrough, target;
    logic                 btb_hit, mispredict;

    assign fetch_idx   = pc_q[IMM_SHIFT +: IDX_W];
    assign br_idx      = br_pc[IMM_SHIFT +: IDX_W];
    assign imm_sext    = {{(ADDR_W-IMM_W){br_imm[IMM_W-1]}}, br_imm};
    assign fallthrough = br_pc + PC_INC_W;
    assign target      = fallthrough + (imm_sext << IMM_SHIFT);
    assign mispredict  = br_valid & (br_taken != br_pred_taken);
    assign btb_hit     = pc_valid_q & btb_valid_q[fetch_idx] & (btb_tag_q[fetch_idx] == pc_q);

    assign pc         = pc_q;
    assign pc_valid   = pc_valid_q;
    assign pred_taken = btb_hit;
    assign redirect   = redirect_q;

    always_comb begin
        pc_d        = pc_q;
        pc_valid_d  = 1'b1;
        redirect_d  = 1'b0;
        btb_valid_d = btb_valid_q;
        btb_tag_d   = btb_tag_q;
        btb_tgt_d   = btb_tgt_q;

        // A mispredict overrides any held fetch; unaccepted pc is simply dropped.
        if (mispredict) begin
            pc_d       = br_taken ? target : fallthrough;
            redirect_d = 1'b1;
        end else if (pc_valid_q && !pc_ready) begin
            pc_d = pc_q;
        end else if (pc_valid_q && btb_hit) begin
            pc_d = btb_tgt_q[fetch_idx];
        end else if (pc_valid_q) begin
            pc_d = pc_q + PC_INC_W;
        end

        if (br_valid) begin
            if (br_taken) begin
                btb_valid_d[br_idx] = 1'b1;
                btb_tag_d[br_idx]   = br_pc;
                btb_tgt_d[br_idx]   = target;
            end else if (btb_tag_q[br_idx] == br_pc) begin
                btb_valid_d[br_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            pc_valid_q  <= 1'b0;
            redirect_q  <= 1'b0;
            btb_valid_q <= '0;
        end else begin
            pc_q        <= pc_d;
            pc_valid_q  <= pc_valid_d;
            redirect_q  <= redirect_d;
            btb_valid_q <= btb_valid_d;
        end
    end

    // Tag and target storage is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        btb_tag_q <= btb_tag_d;
        btb_tgt_q <= btb_tgt_d;
    end

`ifdef PC_BRANCH_PERF_EN
    logic [15:0] br_count_q, br_count_d;
    logic [15:0] mis_count_q, mis_count_d;

    always_comb begin
        br_count_d  = br_count_q;
        mis_count_d = mis_count_q;
        if (br_valid && (br_count_q != 16'hFFFF)) begin
            br_count_d = br_count_q + 16'd1;
        end
        if (mispredict && (mis_count_q != 16'hFFFF)) begin
            mis_count_d = mis_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q  <= '0;
            mis_count_q <= '0;
        end else begin
            br_count_q  <= br_count_d;
            mis_count_q <= mis_count_d;
        end
    end

    assign br_count         = br_count_q;
    assign mispredict_count = mis_count_q;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed self-checking bench for pc_branch_unit: reset, stall, BTB fill/hit/invalidate,
// redirect priority over a stall, and target/fallthrough wrap-around.
module tb_pc_branch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        pred_taken;
    logic        redirect;
    logic        br_valid;
    logic        br_taken;
    logic        br_pred_taken;
    logic [31:0] br_pc;
    logic [23:0] br_imm;
`ifdef PC_BRANCH_PERF_EN
    logic [15:0] br_count;
    logic [15:0] mispredict_count;
`endif

    int compared   = 0;
    int mismatched = 0;

    pc_branch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .pc_ready      (pc_ready),
        .pred_taken    (pred_taken),
        .redirect      (redirect),
        .br_valid      (br_valid),
        .br_taken      (br_taken),
        .br_pred_taken (br_pred_taken),
        .br_pc         (br_pc),
`ifdef PC_BRANCH_PERF_EN
        .br_count         (br_count),
        .mispredict_count (mispredict_count),
`endif
        .br_imm        (br_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [31:0] bpc, input logic [23:0] imm,
                                 input logic t, input logic pt, input logic rdy);
        br_valid      = v;
        br_pc         = bpc;
        br_imm        = imm;
        br_taken      = t;
        br_pred_taken = pt;
        pc_ready      = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 24'h0, 1'b0, 1'b0, 1'b1);
        cycle();
        cycle();
        checkOutput("reset_pc", pc, 32'h0);
        checkOutput("reset_pc_valid", {31'b0, pc_valid}, 32'h0);
        checkOutput("reset_pred", {31'b0, pred_taken}, 32'h0);
        checkOutput("reset_redirect", {31'b0, redirect}, 32'h0);

        rst_n = 1'b1;
        cycle();
        checkOutput("first_valid", {31'b0, pc_valid}, 32'h1);
        checkOutput("seq_pc0", pc, 32'h0);
        cycle();
        checkOutput("seq_pc4", pc, 32'h4);
        cycle();
        checkOutput("seq_pc8", pc, 32'h8);
        checkOutput("seq_pred", {31'b0, pred_taken}, 32'h0);
        checkOutput("seq_redirect", {31'b0, redirect}, 32'h0);

        applyStimulus(1'b0, 32'h0, 24'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkOutput("stall_hold_pc", pc, 32'h8);
            checkOutput("stall_valid", {31'b0, pc_valid}, 32'h1);
        end
        applyStimulus(1'b0, 32'h0, 24'h0, 1'b0, 1'b0, 1'b1);
        cycle();
        checkOutput("stall_release", pc, 32'hC);

        applyStimulus(1'b1, 32'h100, 24'hFFFFFE, 1'b1, 1'b0, 1'b1);
        cycle();
        checkOutput("mp_taken_pc", pc, 32'hFC);
        checkOutput("mp_taken_redirect", {31'b0, redirect}, 32'h1);
        checkOutput("mp_taken_pred_fc", {31'b0, pred_taken}, 32'h0);

        applyStimulus(1'b0, 32'h0, 24'h0, 1'b0, 1'b0, 1'b1);
        cycle();
        checkOutput("fetch_100", pc, 32'h100);
        checkOutput("redirect_one_cycle", {31'b0, redirect}, 32'h0);
        checkOutput("btb_hit_100", {31'b0, pred_taken}, 32'h1);
        cycle();
        checkOutput("btb_follow_pc", pc, 32'hFC);
        checkOutput("btb_follow_redirect", {31'b0, redirect}, 32'h0);

        applyStimulus(1'b1, 32'h100, 24'hFFFFFE, 1'b1, 1'b1, 1'b1);
        cycle();
        checkOutput("correct_pred_pc", pc, 32'h100);
        checkOutput("correct_pred_redirect", {31'b0, redirect}, 32'h0);
        checkOutput("correct_pred_hit", {31'b0, pred_taken}, 32'h1);

        applyStimulus(1'b1, 32'h100, 24'hFFFFFE, 1'b0, 1'b1, 1'b1);
        cycle();
        checkOutput("mp_nt_pc", pc, 32'h104);
        checkOutput("mp_nt_redirect", {31'b0, redirect}, 32'h1);

        applyStimulus(1'b1, 32'hFC, 24'h0, 1'b0, 1'b1, 1'b1);
        cycle();
        checkOutput("refetch_100", pc, 32'h100);
        checkOutput("refetch_redirect", {31'b0, redirect}, 32'h1);
        checkOutput("invalidated_pred", {31'b0, pred_taken}, 32'h0);

        applyStimulus(1'b0, 32'h0, 24'h0, 1'b0, 1'b0, 1'b1);
        cycle();
        checkOutput("after_inval_pc", pc, 32'h104);
        checkOutput("after_inval_redirect", {31'b0, redirect}, 32'h0);

        applyStimulus(1'b0, 32'h0, 24'h0, 1'b0, 1'b0, 1'b0);
        cycle();
        checkOutput("pre_wrap_hold", pc, 32'h104);

        applyStimulus(1'b1, 32'hFFFFFFF8, 24'h000001, 1'b1, 1'b0, 1'b0);
        cycle();
        checkOutput("wrap_target_pc", pc, 32'h0);
        checkOutput("wrap_redirect", {31'b0, redirect}, 32'h1);

        applyStimulus(1'b0, 32'h0, 24'h0, 1'b0, 1'b0, 1'b0);
        cycle();
        checkOutput("wrap_hold_pc", pc, 32'h0);
        checkOutput("wrap_hold_redirect", {31'b0, redirect}, 32'h0);
        checkOutput("wrap_hold_pred", {31'b0, pred_taken}, 32'h0);

        applyStimulus(1'b1, 32'h0, 24'h7FFFFF, 1'b1, 1'b0, 1'b1);
        cycle();
        checkOutput("max_imm_target", pc, 32'h02000000);
        checkOutput("max_imm_redirect", {31'b0, redirect}, 32'h1);
        checkOutput("max_imm_pred", {31'b0, pred_taken}, 32'h0);

        applyStimulus(1'b1, 32'hFFFFFFFC, 24'h0, 1'b0, 1'b1, 1'b1);
        cycle();
        checkOutput("wrap_fallthrough", pc, 32'h0);
        checkOutput("wrap_ft_redirect", {31'b0, redirect}, 32'h1);
        checkOutput("tag_zero_hit", {31'b0, pred_taken}, 32'h1);

        applyStimulus(1'b0, 32'h0, 24'h0, 1'b0, 1'b0, 1'b1);
        cycle();
        checkOutput("tag_zero_follow", pc, 32'h02000000);
        checkOutput("tag_zero_redirect", {31'b0, redirect}, 32'h0);

`ifdef PC_BRANCH_PERF_EN
        checkOutput("perf_br_count", {16'b0, br_count}, 32'd7);
        checkOutput("perf_mp_count", {16'b0, mispredict_count}, 32'd6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
